// File: rtl/tinyalu_arbiter_if.sv
// tinyalu_arbiter_if: groups the requester bus and the tinyalu-side bus of
// the arbiter into one bundle.
//   slave  modport : the arbiter (samples requests and ALU done/result,
//                    drives acks, responses and ALU operands/start)
//   master modport : the environment (requesters plus the ALU itself)
// Requester i uses req[i], req_a[8i+7:8i], req_b[8i+7:8i], req_op[3i+2:3i].
interface tinyalu_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   ack;
  logic [15:0]        rsp_result;
  logic               rsp_err;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [2:0]         alu_op;
  logic               alu_start;
  logic               alu_done;
  logic [15:0]        alu_result;

  modport slave (
    input  req, req_a, req_b, req_op, alu_done, alu_result,
    output ack, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start
  );

  modport master (
    output req, req_a, req_b, req_op, alu_done, alu_result,
    input  ack, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin arbiter/sequencer sharing one tinyalu between
// N_REQ requesters.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : tinyalu_arbiter_if.slave (requests, one-hot ack + response,
//           ALU operand/start/done/result)
// Optional macro TINYALU_ARB_WATCHDOG_EN adds a BUSY timeout of TIMEOUT
// cycles that ends the operation with rsp_err=1.
//
// state | meaning
// IDLE  | arbitrate, latch the winner's operands
// BUSY  | alu_start high, waiting for alu_done (no_op: one cycle only)
// RESP  | load ack/rsp for the granted requester, update last grant
module tinyalu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  tinyalu_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [2:0] OP_NOP = 3'b000;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              start_q, start_d;
  logic [15:0]       res_q, res_d;
  logic              err_q, err_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [15:0]       rsp_result_q, rsp_result_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef TINYALU_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
`endif

  // Round-robin search starting one past the last served requester.
  logic             found;
  logic [IDX_W-1:0] sel;
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    start_d      = start_q;
    res_d        = res_q;
    err_d        = err_q;
    ack_d        = '0;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;
`ifdef TINYALU_ARB_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // The ack cycle is spent in IDLE; the just-served requester may
        // still hold req then, so arbitration waits until ack has cleared.
        if (found && ack_q == '0) begin
          grant_d  = sel;
          alu_a_d  = bus.req_a[8*int'(sel) +: 8];
          alu_b_d  = bus.req_b[8*int'(sel) +: 8];
          alu_op_d = bus.req_op[3*int'(sel) +: 3];
`ifdef TINYALU_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
          case (bus.req_op[3*int'(sel) +: 3])
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
              start_d = 1'b1;
              state_d = BUSY;
            end
            default: begin
              res_d   = '0;
              err_d   = 1'b1;
              state_d = RESP;
            end
          endcase
        end
      end
      BUSY: begin
        if (alu_op_q == OP_NOP) begin
          start_d = 1'b0;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (bus.alu_done) begin
          start_d = 1'b0;
          res_d   = bus.alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef TINYALU_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        ack_d        = N_REQ'(1) << grant_q;
        rsp_result_d = res_q;
        rsp_err_d    = err_q;
        last_d       = grant_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_op_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      start_q      <= 1'b0;
      res_q        <= '0;
      err_q        <= 1'b0;
      ack_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef TINYALU_ARB_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      start_q      <= start_d;
      res_q        <= res_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
`ifdef TINYALU_ARB_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_start  = start_q;
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Bench for tinyalu_arbiter: directed requests, expected responses pushed to
// a scoreboard queue and popped by an independent ack monitor. A small
// tinyalu model answers alu_start (1 cycle for add/and/xor, 3 for mul).
module tb_tinyalu_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tinyalu_arbiter_if #(.N_REQ(N)) bus();

  tinyalu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ack monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && bus.ack !== '0) begin
      n_acks++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b expected no ack", bus.ack);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_vec", 32'(bus.ack), 32'(1) << mon_e.idx);
        chk("rsp_result", 32'(bus.rsp_result), 32'(mon_e.res));
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  // tinyalu model.
  logic alu_hang = 1'b0;
  int   alu_cnt  = 0;

  function automatic int alu_lat(input logic [2:0] op);
    return (op == 3'b100) ? 3 : 1;
  endfunction

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.alu_done <= 1'b0;
    if (bus.alu_start && !bus.alu_done && !alu_hang) begin
      if (alu_cnt >= alu_lat(bus.alu_op) - 1) begin
        bus.alu_done   <= 1'b1;
        bus.alu_result <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
        alu_cnt        <= 0;
      end else begin
        alu_cnt <= alu_cnt + 1;
      end
    end else begin
      alu_cnt <= 0;
    end
  end

  // Operand stability during BUSY and start-low gap between operations.
  logic        prev_start = 1'b0;
  logic        had_op     = 1'b0;
  logic        start_seen = 1'b0;
  logic [18:0] held       = '0;
  int          gap        = 0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (bus.alu_start === 1'b1) begin
      start_seen = 1'b1;
      busy_cycles++;
      if (prev_start) begin
        chk("op_stable", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(held));
      end else begin
        if (had_op) begin
          checks++;
          if (gap < 2) begin
            errors++;
            $display("FAIL start_gap: got %0d low cycles expected >= 2", gap);
          end
        end
        held   = {bus.alu_a, bus.alu_b, bus.alu_op};
        had_op = 1'b1;
      end
      gap = 0;
    end else begin
      gap++;
    end
    prev_start = bus.alu_start;
  end

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
    bus.req_op[3*i +: 3] = op;
    bus.req[i]           = 1'b1;
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [15:0] r, input logic e);
    exp_t x;
    x.idx = i;
    x.res = r;
    x.err = e;
    sb.push_back(x);
    drive(i, a, b, op);
  endtask

  // Waits (bounded) for ack[i]; lat counts rising edges since the call.
  task automatic wait_ack(input int i, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ack[i] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack[%0d] expected one within 2000 cycles", i);
    end
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_any(output int idx);
    idx = -1;
    for (int c = 0; c < 500 && idx < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (bus.ack[k] === 1'b1) idx = k;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_any: got no ack expected one within 500 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int lat;
  int got_idx;
  int n0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  bit rr_reissued;

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;
    bus.req_op = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(bus.ack), 32'h0);
    chk("reset_start", 32'(bus.alu_start), 32'h0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'h0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("reset_alu_ops", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single add: 3 + 4, ALU latency 1 -> ack after 4 edges.
    issue(0, 8'h03, 8'h04, 3'b001, 16'h0007, 1'b0);
    wait_ack(0, lat);
    chk("add_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk);

    // mul FF*FF; operands of requester 2 change mid-operation with no effect.
    issue(2, 8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0);
    @(negedge clk);
    bus.req_a[23:16] = 8'h00;
    bus.req_b[23:16] = 8'h11;
    wait_ack(2, lat);
    chk("mul_latency", 32'(lat), 32'd5);
    repeat (2) @(negedge clk);

    // rst_op and invalid op: error response two cycles after req, no start.
    start_seen = 1'b0;
    issue(1, 8'h12, 8'h34, 3'b111, 16'h0000, 1'b1);
    wait_ack(1, lat);
    chk("rstop_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);
    issue(1, 8'h56, 8'h78, 3'b101, 16'h0000, 1'b1);
    wait_ack(1, lat);
    chk("invalid_latency", 32'(lat), 32'd2);
    chk("invalid_no_start", 32'(start_seen), 32'h0);
    repeat (2) @(negedge clk);

    // no_op: one start cycle, zero result, latency 3.
    issue(0, 8'h9A, 8'hBC, 3'b000, 16'h0000, 1'b0);
    wait_ack(0, lat);
    chk("noop_latency", 32'(lat), 32'd3);

    // Round robin from reset with all four pending; 0 re-requests after service.
    do_reset();
    issue(0, 8'h10, 8'h20, 3'b001, 16'h0030, 1'b0);
    issue(1, 8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0);
    issue(2, 8'hAA, 8'h0F, 3'b011, 16'h00A5, 1'b0);
    issue(3, 8'h12, 8'h10, 3'b100, 16'h0120, 1'b0);
    rr_reissued = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_any(got_idx);
      chk("rr_order", 32'(got_idx), 32'(rr_exp[k]));
      if (got_idx >= 0) bus.req[got_idx] = 1'b0;
      if (got_idx == 0 && !rr_reissued) begin
        rr_reissued = 1'b1;
        issue(0, 8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0);
      end
    end
    repeat (2) @(negedge clk);

    // Reset while BUSY on a mul that never completes.
    alu_hang = 1'b1;
    drive(2, 8'h07, 8'h09, 3'b100);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", 32'(bus.alu_start), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_start", 32'(bus.alu_start), 32'h0);
    chk("reset_async_ack", 32'(bus.ack), 32'h0);
    bus.req  = '0;
    alu_hang = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 8'h01, 8'h01, 3'b001, 16'h0002, 1'b0);
    issue(3, 8'h55, 8'hAA, 3'b011, 16'h00FF, 1'b0);
    wait_any(got_idx);
    chk("post_reset_first", 32'(got_idx), 32'd0);
    if (got_idx >= 0) bus.req[got_idx] = 1'b0;
    wait_any(got_idx);
    chk("post_reset_second", 32'(got_idx), 32'd3);
    if (got_idx >= 0) bus.req[got_idx] = 1'b0;
    repeat (2) @(negedge clk);

    // ALU that never answers.
    alu_hang = 1'b1;
`ifdef TINYALU_ARB_WATCHDOG_EN
    busy_cycles = 0;
    issue(2, 8'h01, 8'h02, 3'b001, 16'h0000, 1'b1);
    wait_ack(2, lat);
    chk("wd_busy_cycles", 32'(busy_cycles), 32'(TO));
    chk("wd_latency", 32'(lat), 32'(TO + 2));
`else
    n0 = n_acks;
    drive(2, 8'h01, 8'h02, 3'b001);
    repeat (1000) @(negedge clk);
    chk("no_wd_no_ack", 32'(n_acks), 32'(n0));
    chk("no_wd_still_busy", 32'(bus.alu_start), 32'h1);
`endif
    alu_hang = 1'b0;
    do_reset();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
